// File: rtl/servant_loadram_pkg.sv
`default_nettype none
// ============================================================================
//  servant_loadram_pkg
//  Shared loader state encodings and small helpers for servant_loadram.
//  Revision: 1.0
// ============================================================================
package servant_loadram_pkg;
  `include "servant_loadram_defs.vh"

  typedef logic [1:0] ld_state_t;

  // The CPU is held while the loader is actively assembling or writing words.
  function automatic logic st_busy(input ld_state_t s);
    return (s == ST_FILL) || (s == ST_WRITE);
  endfunction
endpackage
`default_nettype wire

// File: rtl/servant_ld_pack.sv
`default_nettype none
// ============================================================================
//  servant_ld_pack
//  Assembles a little-endian 32-bit word from a byte stream and tracks which
//  byte lanes have been filled so far.
//  Revision: 1.0
// ============================================================================
module servant_ld_pack (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_data,
  output logic [1:0]  o_idx,
  output logic [31:0] o_word,
  output logic [3:0]  o_mask
);

  logic [1:0]  r_idx;
  logic [31:0] r_word;
  logic [3:0]  r_mask;

  // Byte index and lane mask restart on reset or clear; the word itself
  // only matters in lanes flagged by the mask, so it is never cleared.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_idx  <= 2'd0;
      r_mask <= 4'b0000;
    end else if (i_accept) begin
      r_word[{r_idx, 3'b000} +: 8] <= i_data;
      r_mask[r_idx]                <= 1'b1;
      r_idx                        <= r_idx + 2'd1;
    end
  end

  assign o_idx  = r_idx;
  assign o_word = r_word;
  assign o_mask = r_mask;

endmodule
`default_nettype wire

// File: rtl/servant_loadram_defs.vh
`default_nettype none
// ============================================================================
//  servant_loadram_defs.vh
//  Loader FSM state encodings shared by the servant_loadram RAM and its helpers.
//  Revision: 1.0
// ============================================================================
`ifndef SERVANT_LOADRAM_DEFS_VH
`define SERVANT_LOADRAM_DEFS_VH
localparam logic [1:0] ST_IDLE  = 2'd0;
localparam logic [1:0] ST_FILL  = 2'd1;
localparam logic [1:0] ST_WRITE = 2'd2;
localparam logic [1:0] ST_DONE  = 2'd3;
`endif
`default_nettype wire

// File: rtl/servant_loadram.sv
`default_nettype none
// ============================================================================
//  servant_loadram
//  Wishbone byte-enabled RAM with a byte-stream loader that fills it from
//  LOAD_BASE while holding the CPU in reset.
//  Revision: 1.0
// ============================================================================
module servant_loadram
  import servant_loadram_pkg::*;
#(
  parameter int    DEPTH          = 256,
  parameter int    AW             = $clog2(DEPTH),
  parameter int    LOAD_BASE      = 0,
  parameter int    LOAD_WORDS     = DEPTH / 4,
  parameter string RESET_STRATEGY = "",
  parameter string MEMFILE        = ""
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst,
  input  logic [AW-1:2] i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  input  logic          i_ld_start,
  input  logic          i_ld_valid,
  input  logic [7:0]    i_ld_data,
  output logic          o_ld_ready,
  input  logic          i_ld_flush,
  output logic          o_ld_busy,
  output logic          o_ld_done,
  output logic          o_ld_ovf,
  output logic [AW-2:0] o_ld_words,
  output logic          o_cpu_rst
);

  localparam logic [AW-3:0] c_ptr_base  = (AW-2)'(LOAD_BASE);
  localparam logic [AW-2:0] c_words_max = (AW-1)'(LOAD_WORDS);

  logic [31:0]   r_mem [0:DEPTH/4-1];
  ld_state_t     r_state;
  ld_state_t     w_next;
  logic [AW-3:0] r_ptr;
  logic [AW-2:0] r_words;
  logic          r_ovf;
  logic          r_flush;
  logic          r_ack;
  logic [31:0]   r_rdt;

  logic [1:0]    w_idx;
  logic [31:0]   w_pack_word;
  logic [3:0]    w_pack_mask;
  logic          w_fill_acc;
  logic          w_in_write;
  logic          w_last_word;
  logic          w_ld_we;
  logic          w_ack_set;
  logic          w_wb_we;
  logic [3:0]    w_we;
  logic [AW-3:0] w_waddr;
  logic [31:0]   w_wdata;

  assign w_in_write  = (r_state == ST_WRITE);
  assign w_fill_acc  = (r_state == ST_FILL) && i_ld_valid && !i_ld_start;
  assign w_last_word = ((r_words + 1'b1) == c_words_max);
  assign w_ld_we     = w_in_write && !i_ld_start;
  assign w_ack_set   = i_wb_cyc && !r_ack && !w_in_write;
  assign w_wb_we     = w_ack_set && i_wb_we;

  servant_ld_pack u_pack (
    .i_clk    (i_wb_clk),
    .i_rst    (i_wb_rst),
    .i_clear  (i_ld_start || w_in_write),
    .i_accept (w_fill_acc),
    .i_data   (i_ld_data),
    .o_idx    (w_idx),
    .o_word   (w_pack_word),
    .o_mask   (w_pack_mask)
  );

  // Next loader state; start overrides everything else.
  always_comb begin
    w_next = r_state;
    if (i_ld_start) begin
      w_next = ST_FILL;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_fill_acc && (w_idx == 2'd3))
            w_next = ST_WRITE;
          else if (i_ld_flush)
            w_next = (w_fill_acc || (w_idx != 2'd0)) ? ST_WRITE : ST_DONE;
        end
        ST_WRITE: w_next = (r_flush || w_last_word) ? ST_DONE : ST_FILL;
        default:  w_next = r_state;
      endcase
    end
  end

  // Loader state, word pointer, word counter, overflow and pending-flush flag.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_words <= '0;
      r_ovf   <= 1'b0;
      r_flush <= 1'b0;
    end else if (i_ld_start) begin
      r_state <= ST_FILL;
      r_ptr   <= c_ptr_base;
      r_words <= '0;
      r_ovf   <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_FILL)
        r_flush <= i_ld_flush;
      if (w_in_write) begin
        r_words <= r_words + 1'b1;
        // Hold the pointer on the final word so it never leaves the window.
        if (!w_last_word)
          r_ptr <= r_ptr + 1'b1;
      end
      if ((r_state == ST_DONE) && i_ld_valid)
        r_ovf <= 1'b1;
    end
  end

  // Single write port: the loader owns it in WRITE, otherwise the bus does.
  always_comb begin
    w_we    = 4'b0000;
    w_waddr = i_wb_adr;
    w_wdata = i_wb_dat;
    if (w_ld_we) begin
      w_we    = w_pack_mask;
      w_waddr = r_ptr;
      w_wdata = w_pack_word;
    end else if (w_wb_we) begin
      w_we = i_wb_sel;
    end
  end

  // Byte-enabled RAM write and registered read (old data on collision).
  always_ff @(posedge i_wb_clk) begin
    for (int b = 0; b < 4; b++)
      if (w_we[b])
        r_mem[w_waddr][8*b +: 8] <= w_wdata[8*b +: 8];
    r_rdt <= r_mem[i_wb_adr];
  end

  generate
    if (RESET_STRATEGY == "NONE") begin : g_ack_norst
      // Acknowledge every other cycle, stalled while the loader writes.
      always_ff @(posedge i_wb_clk) r_ack <= w_ack_set;
    end else begin : g_ack_rst
      // Acknowledge every other cycle, stalled while the loader writes.
      always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) r_ack <= 1'b0;
        else          r_ack <= w_ack_set;
      end
    end
  endgenerate

  assign o_wb_rdt   = r_rdt;
  assign o_wb_ack   = r_ack;
  assign o_ld_ready = !w_in_write;
  assign o_ld_busy  = st_busy(r_state);
  assign o_ld_done  = (r_state == ST_DONE);
  assign o_ld_ovf   = r_ovf;
  assign o_ld_words = r_words;
  assign o_cpu_rst  = st_busy(r_state);

endmodule
`default_nettype wire

// File: tb/tb_servant_loadram.sv
`default_nettype none
// ============================================================================
//  tb_servant_loadram
//  Self-checking bench: wishbone vector table, directed loader sequences and
//  randomized load sessions against a byte-level memory model.
//  Revision: 1.0
// ============================================================================
module tb_servant_loadram;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int BASE  = 2;
  localparam int LW    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic        ld_start, ld_valid, ld_flush;
  logic [7:0]  ld_data;
  logic        ld_ready, ld_busy, ld_done, ld_ovf, cpu_rst;
  logic [4:0]  ld_words;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_mem [16];

  always #5 clk = ~clk;

  servant_loadram #(.DEPTH(DEPTH), .LOAD_BASE(BASE), .LOAD_WORDS(LW)) dut (
    .i_wb_clk(clk), .i_wb_rst(rst), .i_wb_adr(wb_adr), .i_wb_dat(wb_dat),
    .i_wb_sel(wb_sel), .i_wb_we(wb_we), .i_wb_cyc(wb_cyc), .o_wb_rdt(wb_rdt),
    .o_wb_ack(wb_ack), .i_ld_start(ld_start), .i_ld_valid(ld_valid),
    .i_ld_data(ld_data), .o_ld_ready(ld_ready), .i_ld_flush(ld_flush),
    .o_ld_busy(ld_busy), .o_ld_done(ld_done), .o_ld_ovf(ld_ovf),
    .o_ld_words(ld_words), .o_cpu_rst(cpu_rst)
  );

  typedef struct {
    logic        we;
    logic [3:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } wb_vec_t;

  wb_vec_t vt [0:8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdt);
    logic got = 1'b0;
    wb_cyc = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wb_ack) begin got = 1'b1; break; end
    end
    rdt = wb_rdt;
    wb_cyc = 1'b0; wb_we = 1'b0;
    if (!got) begin
      n_checks++; n_errors++;
      $display("FAIL wb_ack_timeout: got no ack expected ack within 10 cycles");
    end else if (we) begin
      m_mem[adr] = merge(m_mem[adr], dat, sel);
    end
    tick();
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] adr, input logic [31:0] exp);
    logic [31:0] r;
    wb_xfer(1'b0, adr, 32'h0, 4'h0, r);
    chk(nm, r, exp);
  endtask

  task automatic ld_go();
    ld_start = 1'b1; tick(); ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc = 1'b0;
    logic rdy;
    ld_valid = 1'b1; ld_data = b;
    for (int i = 0; i < 10; i++) begin
      rdy = ld_ready;
      tick();
      if (rdy) begin acc = 1'b1; break; end
    end
    ld_valid = 1'b0;
    if (!acc) begin
      n_checks++; n_errors++;
      $display("FAIL ld_ready_timeout: got ready=0 expected ready within 10 cycles");
    end
  endtask

  task automatic ld_end();
    for (int i = 0; i < 10; i++) begin
      if (ld_ready) break;
      tick();
    end
    ld_flush = 1'b1; tick(); ld_flush = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!ld_busy) break;
      tick();
    end
    if (ld_busy) begin
      n_checks++; n_errors++;
      $display("FAIL busy_timeout: got busy=1 expected busy=0 within 20 cycles");
    end
  endtask

  // Random session: model places the first 4*LW bytes little-endian from BASE.
  task automatic rand_session(input int n);
    logic [7:0] q [$];
    int loaded;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    ld_go();
    foreach (q[i]) begin
      repeat ($urandom_range(0, 2)) tick();
      send_byte(q[i]);
    end
    ld_end();
    wait_idle();
    loaded = (n < 4*LW) ? n : 4*LW;
    for (int k = 0; k < loaded; k++) m_mem[BASE + k/4][8*(k%4) +: 8] = q[k];
    chk("rand_words", 32'(ld_words), 32'((loaded + 3) / 4));
    chk("rand_done", 32'(ld_done), 32'd1);
    chk("rand_ovf", 32'(ld_ovf), 32'(n > 4*LW));
    chk("rand_cpu_rst", 32'(cpu_rst), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    rst = 1'b1; wb_cyc = 0; wb_we = 0; wb_adr = 0; wb_dat = 0; wb_sel = 0;
    ld_start = 0; ld_valid = 0; ld_flush = 0; ld_data = 0;
    repeat (3) tick();
    chk("rst_ack", 32'(wb_ack), 32'd0);
    chk("rst_busy", 32'(ld_busy), 32'd0);
    chk("rst_done", 32'(ld_done), 32'd0);
    chk("rst_ovf", 32'(ld_ovf), 32'd0);
    chk("rst_words", 32'(ld_words), 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("rst_ready", 32'(ld_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Known contents everywhere.
    for (int i = 0; i < 16; i++) wb_xfer(1'b1, 4'(i), 32'hC0DE0000 | i, 4'hF, r);

    // Wishbone vector table.
    vt[0] = '{1'b1, 4'd5, 32'hAABBCCDD, 4'b0001, 32'h0};
    vt[1] = '{1'b1, 4'd6, 32'h11223344, 4'b1100, 32'h0};
    vt[2] = '{1'b1, 4'd7, 32'h55667788, 4'b1111, 32'h0};
    vt[3] = '{1'b1, 4'd8, 32'hFFFFFFFF, 4'b0000, 32'h0};
    vt[4] = '{1'b1, 4'd9, 32'h0000BEEF, 4'b0110, 32'h0};
    vt[5] = '{1'b0, 4'd5, 32'h0, 4'h0, 32'hC0DE00DD};
    vt[6] = '{1'b0, 4'd6, 32'h0, 4'h0, 32'h11220006};
    vt[7] = '{1'b0, 4'd8, 32'h0, 4'h0, 32'hC0DE0008};
    vt[8] = '{1'b0, 4'd9, 32'h0, 4'h0, 32'hC000BE09};
    for (int i = 0; i <= 8; i++) begin
      wb_xfer(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, r);
      if (!vt[i].we) chk($sformatf("vec%0d_rdt", i), r, vt[i].exp);
    end

    // Back-to-back reads: ack alternates, data valid with ack.
    wb_cyc = 1'b1; wb_we = 1'b0; wb_adr = 4'd7;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("b2b_ack", 32'(wb_ack), 32'((i % 2) == 0));
      if (wb_ack) chk("b2b_rdt", wb_rdt, 32'h55667788);
    end
    wb_cyc = 1'b0; tick();

    // Eight-byte load fills two words.
    ld_go();
    chk("load8_cpu_rst", 32'(cpu_rst), 32'd1);
    for (int i = 1; i <= 8; i++) send_byte(8'(i * 8'h11));
    wait_idle();
    chk("load8_words", 32'(ld_words), 32'd2);
    chk("load8_done", 32'(ld_done), 32'd1);
    rd_chk("load8_w0", 4'(BASE), 32'h44332211);
    rd_chk("load8_w1", 4'(BASE + 1), 32'h88776655);

    // Partial word then flush.
    ld_go();
    chk("flush_busy", 32'(ld_busy), 32'd1);
    send_byte(8'hAA); send_byte(8'hBB);
    ld_end();
    wait_idle();
    chk("flush_done", 32'(ld_done), 32'd1);
    chk("flush_words", 32'(ld_words), 32'd1);
    chk("flush_ovf0", 32'(ld_ovf), 32'd0);
    rd_chk("flush_w0", 4'(BASE), 32'h4433BBAA);
    send_byte(8'h5A);
    chk("flush_ovf1", 32'(ld_ovf), 32'd1);

    // Overrun: twelve bytes into a two-word window.
    ld_go();
    for (int i = 1; i <= 12; i++) send_byte(8'(i));
    wait_idle();
    chk("ovr_words", 32'(ld_words), 32'd2);
    chk("ovr_done", 32'(ld_done), 32'd1);
    chk("ovr_ovf", 32'(ld_ovf), 32'd1);
    rd_chk("ovr_w0", 4'(BASE), 32'h04030201);
    rd_chk("ovr_w1", 4'(BASE + 1), 32'h08070605);
    rd_chk("ovr_next", 4'(BASE + 2), 32'hC0DE0004);

    // Bus write colliding with loader WRITE to the same word.
    ld_go();
    for (int i = 1; i <= 8; i++) send_byte(8'(8'h20 + i));
    chk("col_in_write", 32'(ld_ready), 32'd0);
    wb_cyc = 1'b1; wb_we = 1'b1; wb_adr = 4'd3; wb_dat = 32'hDEADBEEF; wb_sel = 4'b0101;
    tick();
    chk("col_ack_stall", 32'(wb_ack), 32'd0);
    tick();
    chk("col_ack_late", 32'(wb_ack), 32'd1);
    wb_cyc = 1'b0; wb_we = 1'b0;
    tick();
    rd_chk("col_w2", 4'd2, 32'h24232221);
    rd_chk("col_w3", 4'd3, 32'h28AD26EF);

    // Reset mid-load abandons the partial word.
    ld_go();
    send_byte(8'h91); send_byte(8'h92); send_byte(8'h93);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mrst_busy", 32'(ld_busy), 32'd0);
    chk("mrst_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("mrst_done", 32'(ld_done), 32'd0);
    chk("mrst_words", 32'(ld_words), 32'd0);
    rd_chk("mrst_w2", 4'd2, 32'h24232221);
    ld_go();
    send_byte(8'h9A); send_byte(8'h9B); send_byte(8'h9C); send_byte(8'h9D);
    ld_end();
    wait_idle();
    chk("mrst_re_words", 32'(ld_words), 32'd1);
    rd_chk("mrst_re_w2", 4'd2, 32'h9D9C9B9A);
    rd_chk("mrst_re_w3", 4'd3, 32'h28AD26EF);

    // Resynchronise the model with directed results above.
    m_mem[2] = 32'h9D9C9B9A; m_mem[3] = 32'h28AD26EF;

    // Randomized bus writes and load sessions against the model.
    for (int s = 0; s < 15; s++) begin
      wb_xfer(1'b1, 4'($urandom_range(0, 15)), $urandom, 4'($urandom), r);
      rand_session($urandom_range(0, 11));
    end
    for (int i = 0; i < 16; i++) rd_chk($sformatf("final_w%0d", i), 4'(i), m_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
